// File: rtl/sd_regs_if.sv
// Host bus and controller update port of the SD host register bank.
interface sd_regs_if #(
    parameter int ADDR_W = 7
);
    logic              host_wr_en;
    logic              host_rd_en;
    logic [ADDR_W-1:0] host_addr;
    logic [1:0]        host_be;
    logic [15:0]       host_wr_data;
    logic [15:0]       host_rd_data;
    logic              host_rd_valid;
    logic              ctl_wr_en;
    logic [ADDR_W-1:0] ctl_addr;
    logic [15:0]       ctl_wr_mask;
    logic [15:0]       ctl_wr_data;

    modport master (
        output host_wr_en, host_rd_en, host_addr, host_be, host_wr_data,
        output ctl_wr_en, ctl_addr, ctl_wr_mask, ctl_wr_data,
        input  host_rd_data, host_rd_valid
    );

    modport slave (
        input  host_wr_en, host_rd_en, host_addr, host_be, host_wr_data,
        input  ctl_wr_en, ctl_addr, ctl_wr_mask, ctl_wr_data,
        output host_rd_data, host_rd_valid
    );
endinterface

// File: rtl/sd_register_file.sv
// SD host controller register bank: host byte-enable port, controller masked update, W1C/RO/self-clear policies, irq.
// Optional SD_REGS_FORCE_EVENT_EN: host writes to words 41/40 force-set bits of words 25/30.
module sd_register_file #(
    parameter int          ADDR_W    = 7,
    parameter int          NUM_WORDS = 128,
    parameter logic [31:0] CAPS      = 32'h0000_0000,
    parameter logic [31:0] MAX_CUR   = 32'h0000_0000,
    parameter logic [15:0] VERSION   = 16'h0002
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sd_regs_if.slave                bus,
    output logic [2:0]              sw_reset_pulse_o,
    output logic                    irq_o,
    output logic [16*NUM_WORDS-1:0] mem_data_o
);
    logic [15:0] mem_q [NUM_WORDS];
    logic [15:0] mem_d [NUM_WORDS];
    logic [15:0] view  [NUM_WORDS];
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q;
    logic        irq_q, irq_d;
    logic [15:0] host_mask, host_bits, nxt;
    logic        host_hit, ctl_hit;

    function automatic logic is_const(input int k);
        return (k == 32) || (k == 33) || (k == 36) || (k == 37) ||
               (k == 40) || (k == 41) || (k == 127);
    endfunction

    function automatic logic is_host_ro(input int k);
        return (k == 16) || (k == 17) || ((k >= 32) && (k <= 41)) ||
               (k == 126) || (k == 127);
    endfunction

    function automatic logic is_w1c(input int k);
        return (k == 24) || (k == 25) || (k == 30);
    endfunction

    function automatic logic [15:0] const_val(input int k);
        case (k)
            32:      const_val = CAPS[15:0];
            33:      const_val = CAPS[31:16];
            36:      const_val = MAX_CUR[15:0];
            37:      const_val = MAX_CUR[31:16];
            127:     const_val = VERSION;
            default: const_val = 16'h0000;
        endcase
    endfunction

`ifdef SD_REGS_FORCE_EVENT_EN
    logic force_err, force_acmd;
    assign force_err  = bus.host_wr_en && (int'(bus.host_addr) == 41);
    assign force_acmd = bus.host_wr_en && (int'(bus.host_addr) == 40);
`endif

    always_comb begin
        host_mask = {{8{bus.host_be[1]}}, {8{bus.host_be[0]}}};
        host_bits = bus.host_wr_data & host_mask;
        nxt       = 16'h0000;
        host_hit  = 1'b0;
        ctl_hit   = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            host_hit = bus.host_wr_en && (int'(bus.host_addr) == k);
            ctl_hit  = bus.ctl_wr_en && (int'(bus.ctl_addr) == k) && !is_const(k);
            nxt      = mem_q[k];
            if (k == 23) nxt[10:8] = 3'b000;
            if (is_w1c(k)) begin
                if (host_hit) nxt = nxt & ~host_bits;
`ifdef SD_REGS_FORCE_EVENT_EN
                if ((k == 25) && force_err)  nxt = nxt | host_bits;
                if ((k == 30) && force_acmd) nxt = nxt | host_bits;
`endif
                // Controller sets always survive a simultaneous host clear.
                if (ctl_hit && host_hit)
                    nxt = nxt | (bus.ctl_wr_data & bus.ctl_wr_mask);
                else if (ctl_hit)
                    nxt = (nxt & ~bus.ctl_wr_mask) | (bus.ctl_wr_data & bus.ctl_wr_mask);
            end else begin
                if (host_hit && !is_host_ro(k))
                    nxt = (nxt & ~host_mask) | host_bits;
                if (ctl_hit)
                    nxt = (nxt & ~bus.ctl_wr_mask) | (bus.ctl_wr_data & bus.ctl_wr_mask);
            end
            if (k == 24) nxt[15] = 1'b0;
            if (is_const(k)) nxt = 16'h0000;
            mem_d[k] = nxt;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++)
            view[k] = is_const(k) ? const_val(k) : mem_q[k];
        view[24][15] = |mem_q[25];
        rd_data_d = rd_data_q;
        if (bus.host_rd_en) begin
            rd_data_d = 16'h0000;
            for (int k = 0; k < NUM_WORDS; k++)
                if (int'(bus.host_addr) == k) rd_data_d = view[k];
        end
        irq_d = (|(view[24] & mem_q[26] & mem_q[28])) |
                (|(mem_q[25] & mem_q[27] & mem_q[29]));
    end

    always_comb begin
        mem_data_o = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            mem_data_o[16*k +: 16] = view[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_WORDS; k++) mem_q[k] <= 16'h0000;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) mem_q[k] <= mem_d[k];
            rd_data_q  <= rd_data_d;
            rd_valid_q <= bus.host_rd_en;
            irq_q      <= irq_d;
        end
    end

    assign bus.host_rd_data  = rd_data_q;
    assign bus.host_rd_valid = rd_valid_q;
    assign sw_reset_pulse_o  = mem_q[23][10:8];
    assign irq_o             = irq_q;
endmodule

// File: tb/tb_sd_register_file.sv
// Directed self-checking bench for sd_register_file.
module tb_sd_register_file;
    localparam int AW = 8;
    localparam int NW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    pulse;
    logic          irq;
    logic [16*NW-1:0] mem_data;
    int            checks = 0;
    int            errors = 0;
    logic [15:0]   rd;
    logic          vld;

    sd_regs_if #(.ADDR_W(AW)) bus ();

    sd_register_file #(
        .ADDR_W(AW), .NUM_WORDS(NW), .CAPS(32'h9ABC_5678),
        .MAX_CUR(32'h0000_00C8), .VERSION(16'h0002)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .sw_reset_pulse_o(pulse), .irq_o(irq), .mem_data_o(mem_data)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word(input int k);
        return mem_data[16*k +: 16];
    endfunction

    task automatic host_write(input logic [AW-1:0] a, input logic [1:0] be, input logic [15:0] d);
        bus.host_wr_en = 1'b1; bus.host_addr = a; bus.host_be = be; bus.host_wr_data = d;
        tick();
        bus.host_wr_en = 1'b0;
    endtask

    task automatic ctl_write(input logic [AW-1:0] a, input logic [15:0] m, input logic [15:0] d);
        bus.ctl_wr_en = 1'b1; bus.ctl_addr = a; bus.ctl_wr_mask = m; bus.ctl_wr_data = d;
        tick();
        bus.ctl_wr_en = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [15:0] d, output logic v);
        bus.host_rd_en = 1'b1; bus.host_addr = a;
        tick();
        bus.host_rd_en = 1'b0;
        d = bus.host_rd_data;
        v = bus.host_rd_valid;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.host_wr_en = 0; bus.host_rd_en = 0; bus.host_addr = '0; bus.host_be = '0;
        bus.host_wr_data = '0; bus.ctl_wr_en = 0; bus.ctl_addr = '0;
        bus.ctl_wr_mask = '0; bus.ctl_wr_data = '0;
        tick(); tick();
        chk("rst_rd_data", bus.host_rd_data, 16'h0000);
        chk("rst_rd_valid", {15'd0, bus.host_rd_valid}, 16'h0000);
        chk("rst_pulse", {13'd0, pulse}, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        rst_n = 1'b1;
        tick();

        host_read(127, rd, vld);
        chk("rd_version", rd, 16'h0002);
        chk("rd_version_valid", {15'd0, vld}, 16'h0001);
        host_read(32, rd, vld);
        chk("rd_caps_lo", rd, 16'h5678);
        host_read(36, rd, vld);
        chk("rd_maxcur_lo", rd, 16'h00C8);
        host_read(0, rd, vld);
        chk("rd_word0", rd, 16'h0000);
        tick();

        // byte enables and read latency
        host_write(2, 2'b11, 16'h1234);
        host_write(2, 2'b01, 16'hABCD);
        chk("be01_mem", word(2), 16'h12CD);
        chk("valid_idle", {15'd0, bus.host_rd_valid}, 16'h0000);
        bus.host_rd_en = 1'b1; bus.host_addr = 2;
        tick();
        bus.host_rd_en = 1'b0;
        chk("be01_rd", bus.host_rd_data, 16'h12CD);
        chk("valid_pulse", {15'd0, bus.host_rd_valid}, 16'h0001);
        tick();
        chk("valid_drop", {15'd0, bus.host_rd_valid}, 16'h0000);
        host_write(2, 2'b10, 16'h55AA);
        chk("be10_mem", word(2), 16'h55CD);

        // read coinciding with write returns old value
        bus.host_rd_en = 1'b1; bus.host_wr_en = 1'b1; bus.host_addr = 2;
        bus.host_be = 2'b11; bus.host_wr_data = 16'h0000;
        tick();
        bus.host_rd_en = 1'b0; bus.host_wr_en = 1'b0;
        chk("rd_prewrite", bus.host_rd_data, 16'h55CD);
        chk("rd_prewrite_mem", word(2), 16'h0000);

        // out of range and back-to-back reads
        host_write(130, 2'b11, 16'hFFFF);
        chk("oor_write", word(2), 16'h0000);
        bus.host_rd_en = 1'b1; bus.host_addr = 127;
        tick();
        chk("b2b_rd0", bus.host_rd_data, 16'h0002);
        bus.host_addr = 130;
        tick();
        bus.host_rd_en = 1'b0;
        chk("b2b_oor_rd", bus.host_rd_data, 16'h0000);
        chk("b2b_valid", {15'd0, bus.host_rd_valid}, 16'h0001);

        // W1C race
        ctl_write(25, 16'h0003, 16'h0003);
        chk("w1c_set", word(25), 16'h0003);
        chk("err_summary_set", word(24), 16'h8000);
        bus.host_wr_en = 1'b1; bus.host_addr = 25; bus.host_be = 2'b11; bus.host_wr_data = 16'h0003;
        bus.ctl_wr_en = 1'b1; bus.ctl_addr = 25; bus.ctl_wr_mask = 16'h0001; bus.ctl_wr_data = 16'h0001;
        tick();
        bus.host_wr_en = 1'b0; bus.ctl_wr_en = 1'b0;
        chk("w1c_race", word(25), 16'h0001);
        chk("w1c_race_summary", word(24), 16'h8000);
        host_write(25, 2'b11, 16'h0001);
        chk("w1c_clear", word(25), 16'h0000);
        chk("summary_clear", word(24), 16'h0000);

        // normal interrupt path
        host_write(26, 2'b11, 16'h0001);
        host_write(28, 2'b11, 16'h0001);
        ctl_write(24, 16'h0001, 16'h0001);
        chk("nirq_status", word(24), 16'h0001);
        chk("nirq_lag", {15'd0, irq}, 16'h0000);
        tick();
        chk("nirq_high", {15'd0, irq}, 16'h0001);
        host_write(24, 2'b11, 16'h0001);
        chk("nirq_status_clr", word(24), 16'h0000);
        chk("nirq_hold", {15'd0, irq}, 16'h0001);
        tick();
        chk("nirq_low", {15'd0, irq}, 16'h0000);

        // error interrupt path
        host_write(27, 2'b11, 16'h0004);
        host_write(29, 2'b11, 16'h0004);
        ctl_write(25, 16'h0004, 16'h0004);
        chk("eirq_lag", {15'd0, irq}, 16'h0000);
        tick();
        chk("eirq_high", {15'd0, irq}, 16'h0001);
        chk("eirq_summary", word(24), 16'h8000);
        host_write(25, 2'b11, 16'h0004);
        tick();
        chk("eirq_low", {15'd0, irq}, 16'h0000);

        // software reset
        host_write(23, 2'b11, 16'h0200);
        chk("swrst_pulse", {13'd0, pulse}, 16'h0002);
        tick();
        chk("swrst_pulse_end", {13'd0, pulse}, 16'h0000);
        host_read(23, rd, vld);
        chk("swrst_rd", rd, 16'h0000);
        host_write(23, 2'b11, 16'h0703);
        chk("swrst_all", {13'd0, pulse}, 16'h0007);
        tick();
        host_read(23, rd, vld);
        chk("swrst_keep_rw", rd, 16'h0003);

        // read-only words
        host_write(127, 2'b11, 16'hFFFF);
        host_read(127, rd, vld);
        chk("ro_version", rd, 16'h0002);
        host_write(33, 2'b11, 16'hFFFF);
        chk("ro_caps_hi", word(33), 16'h9ABC);
        host_write(16, 2'b11, 16'hFFFF);
        chk("ro_pstate_host", word(16), 16'h0000);
        ctl_write(16, 16'hFFFF, 16'h00A5);
        chk("ro_pstate_ctl", word(16), 16'h00A5);
        ctl_write(127, 16'hFFFF, 16'h0000);
        chk("ctl_version", word(127), 16'h0002);
        ctl_write(32, 16'hFFFF, 16'h0000);
        chk("ctl_caps", word(32), 16'h5678);

        // controller masked update and same-cycle merge
        host_write(5, 2'b11, 16'h00FF);
        ctl_write(5, 16'h0F0F, 16'hAAAA);
        chk("ctl_mask", word(5), 16'h0AFA);
        bus.host_wr_en = 1'b1; bus.host_addr = 6; bus.host_be = 2'b11; bus.host_wr_data = 16'h1234;
        bus.ctl_wr_en = 1'b1; bus.ctl_addr = 6; bus.ctl_wr_mask = 16'h00F0; bus.ctl_wr_data = 16'hFFFF;
        tick();
        bus.host_wr_en = 1'b0; bus.ctl_wr_en = 1'b0;
        chk("rw_merge", word(6), 16'h12F4);

        // force event
        host_write(41, 2'b11, 16'h0010);
`ifdef SD_REGS_FORCE_EVENT_EN
        chk("force_err", word(25), 16'h0010);
`else
        chk("force_err", word(25), 16'h0000);
`endif
        chk("force_word41", word(41), 16'h0000);
        host_write(25, 2'b11, 16'h0010);
        chk("force_clear", word(25), 16'h0000);

        // reset mid-operation
        ctl_write(24, 16'h0001, 16'h0001);
        tick();
        chk("pre_rst_irq", {15'd0, irq}, 16'h0001);
        bus.host_rd_en = 1'b1; bus.host_addr = 127;
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_irq", {15'd0, irq}, 16'h0000);
        chk("mid_rst_valid", {15'd0, bus.host_rd_valid}, 16'h0000);
        chk("mid_rst_rd_data", bus.host_rd_data, 16'h0000);
        chk("mid_rst_word5", word(5), 16'h0000);
        bus.host_rd_en = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {15'd0, bus.host_rd_valid}, 16'h0000);
        host_read(32, rd, vld);
        chk("post_rst_caps", rd, 16'h5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_register_file.md
# sd_register_file

Parametrised, clocked register bank for the SD host controller. It stores the standard host register map as NUM_WORDS 16-bit words and gives the host bus a 1-cycle-latency read/write port with byte enables. The controller engine gets a masked update port. Per-register access policies (RW, RO, W1C, self-clearing) and interrupt generation are enforced here. The flat mem_data_out image feeds the existing field-split decode unchanged.

## Interface
Parameters:
- ADDR_W, 7: word-address width.
- NUM_WORDS, 128: number of words; must be ≤ 2**ADDR_W and ≥ 128.
- CAPS, 32'h0000_0000: reset/constant value of capabilities, words 32–33.
- MAX_CUR, 32'h0000_0000: constant value of max current, words 36–37.
- VERSION, 16'h0002: constant value of host controller version, word 127.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- host_wr_en  in  1  host write strobe.
- host_rd_en  in  1  host read strobe.
- host_addr  in  ADDR_W  word address.
- host_be  in  2  byte enables; [0] = bits 7:0, [1] = bits 15:8.
- host_wr_data  in  16  write data.
- host_rd_data  out  16  read data, registered.
- host_rd_valid  out  1  one-cycle pulse, cycle after host_rd_en.
- ctl_wr_en  in  1  controller update strobe.
- ctl_addr  in  ADDR_W  controller word address.
- ctl_wr_mask  in  16  bits to update.
- ctl_wr_data  in  16  update data.
- sw_reset_pulse  out  3  one-cycle pulse per software-reset bit (all/CMD/DAT).
- irq  out  1  registered interrupt request.
- mem_data_out  out  16*NUM_WORDS  flat image; word k at bits [16k+15:16k].

## Operation
- Access classes:
  - RO: words 16–17 (present state), 32–39 (capabilities, max current), 126 (slot interrupt status), 127 (version). Host writes are ignored.
  - W1C: word 24 (normal interrupt status bits 14:0), word 25 (error interrupt status), word 30 (auto CMD12 error status).
  - Self-clearing: word 23 bits 10:8 (software reset).
  - RW: all other words.
- Word 24 bit 15 is the error summary. It is read-only and always equals |word25.
- Host RW write: each byte with host_be set is replaced by host_wr_data.
- Host W1C write: stored bit is cleared where the byte is enabled and the data bit is 1.
- Software reset bits: a host write of 1 asserts the matching sw_reset_pulse bit for one cycle. The stored bits then clear on the next edge. Reads return 0 after that.
- Controller write: stored = (stored & ~ctl_wr_mask) | (ctl_wr_data & ctl_wr_mask). Allowed on any word except 127 and the CAPS/MAX_CUR words.
- Same word, same cycle, host and controller:
  - W1C words: new = (old & ~host_clear) | (ctl_wr_data & ctl_wr_mask). A set always beats a clear, so no event is lost.
  - Other words: host write is applied first, then the controller mask on top (controller wins on masked bits).
- Read returns the pre-write value when it coincides with a write to the same word.
- irq = |(word24 & word26 & word28) | |(word25 & word27 & word29).
- Out-of-range addresses (≥ NUM_WORDS): writes ignored, reads return 0.

## Timing
- Reset values: all words 0 except CAPS, MAX_CUR and VERSION words. host_rd_data = 0, host_rd_valid = 0, sw_reset_pulse = 0, irq = 0.
- Reset asserted mid-transfer aborts it. No pending read completes after rst_n rises.
- Write → mem_data_out update: visible the cycle after the edge.
- Read: host_rd_data and host_rd_valid one cycle after host_rd_en. Back-to-back reads every cycle are supported.
- irq is one cycle behind the status/enable registers: two cycles after a ctl_wr_en that sets a status bit.
- sw_reset_pulse is high exactly one cycle, on the cycle after the host write.

## Configuration
- SD_REGS_FORCE_EVENT_EN defined:
  - A host write to word 41 sets the written-1 bits (byte-enabled) of word 25.
  - A host write to word 40 sets the written-1 bits of word 30.
  - Words 40–41 read as 0.
  - A force and a W1C clear of the same bit in the same cycle leaves the bit set.
- Not defined: words 40–41 read as 0, host writes to them are ignored, and there is no force logic.

## Test plan
- Reset: rst_n low mid-operation → all outputs 0; read word 127 returns VERSION; read word 32 returns CAPS[15:0]; read word 0 returns 0.
- Byte enables: write word 2 = 16'hABCD with be=2'b01 after word 2 = 16'h1234 → read returns 16'h12CD, host_rd_valid one cycle after host_rd_en.
- W1C race: ctl sets word 25 = 16'h0003; same cycle host writes 16'h0003 to word 25 while ctl sets bit 0 again → word 25 = 16'h0001, word 24 bit 15 = 1.
- Interrupt: word 26 = 16'h0001, word 28 = 16'h0001, ctl sets word 24 bit 0 → irq high 2 cycles after ctl_wr_en; host W1C 16'h0001 → irq low 1 cycle later.
- Software reset and RO: host writes word 23 = 16'h0200 → sw_reset_pulse = 3'b010 for exactly one cycle, word 23 reads 0; host write to word 127 leaves VERSION.
- Force event (SD_REGS_FORCE_EVENT_EN): host writes 16'h0010 to word 41 → word 25 = 16'h0010, word 41 reads 0; without the macro word 25 stays 0.
